// File: rtl/vram_access_unit.sv
// VRAM access sequencer: turns CPU register writes and VRR reads into single
// VRAM word accesses placed in the CPU slots left free by the display fetcher.
module vram_access_unit #(
  parameter int         ADDR_W   = 16,
  parameter logic [4:0] REG_MAWR = 5'h00,
  parameter logic [4:0] REG_MARR = 5'h01,
  parameter logic [4:0] REG_VWR  = 5'h02
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              wr_msb,
  input  logic [4:0]        wr_reg,
  input  logic [7:0]        wr_data,
  input  logic              vrr_rd_msb,
  input  logic [1:0]        incr_sel,
  input  logic              slot_free,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic              vram_re,
  output logic [15:0]       vram_wdata,
  input  logic [15:0]       vram_rdata,
  output logic [15:0]       vrr_data,
  output logic              busy,
  output logic              dropped
);

  localparam int HI = ADDR_W - 1;

  // Handshake: the scheduler offers a slot with slot_free; a strobe (we/re)
  // is raised only while a request is pending and the slot is free, and the
  // access is consumed at that same rising edge.
  typedef enum logic [1:0] {IDLE, WPEND, RPEND, RWAIT} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] mawr, marr, inc;
  logic [15:0]       wlatch;
  logic              wt, rt, marr_msb_wr, drop_nx;

  assign wt          = wr_en && wr_msb && (wr_reg == REG_VWR);
  assign marr_msb_wr = wr_en && wr_msb && (wr_reg == REG_MARR);
  assign rt          = marr_msb_wr || vrr_rd_msb;

  always_comb begin
    case (incr_sel)
      2'b00:   inc = ADDR_W'(1);
      2'b01:   inc = ADDR_W'(32);
      2'b10:   inc = ADDR_W'(64);
      default: inc = ADDR_W'(128);
    endcase
  end

  always_comb begin
    state_nx   = state;
    drop_nx    = 1'b0;
    vram_we    = 1'b0;
    vram_re    = 1'b0;
    vram_addr  = '0;
    vram_wdata = '0;
    case (state)
      IDLE: begin
        // a write beats a simultaneous read trigger; the read is lost
        if (wt) begin
          state_nx = WPEND;
          drop_nx  = rt;
        end else if (rt) begin
          state_nx = RPEND;
        end
      end
      WPEND: begin
        drop_nx    = wt || rt;
        vram_we    = slot_free;
        vram_addr  = mawr;
        vram_wdata = wlatch;
        if (slot_free) state_nx = IDLE;
      end
      RPEND: begin
        drop_nx   = wt || rt;
        vram_re   = slot_free;
        vram_addr = marr;
        if (slot_free) state_nx = RWAIT;
      end
      RWAIT: begin
        drop_nx  = wt || rt;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mawr     <= '0;
      marr     <= '0;
      wlatch   <= '0;
      vrr_data <= '0;
      busy     <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      state   <= state_nx;
      busy    <= (state_nx != IDLE);
      dropped <= drop_nx;
      if (state == RWAIT) vrr_data <= vram_rdata;
      // increments first; a byte write in the same cycle overrides its lane
      if (state == WPEND && slot_free) mawr <= mawr + inc;
      if (vrr_rd_msb) marr <= marr + inc;
      if (wr_en && wr_reg == REG_MAWR) begin
        if (wr_msb) mawr[HI:8] <= wr_data[HI-8:0];
        else        mawr[7:0]  <= wr_data;
      end
      if (wr_en && wr_reg == REG_MARR) begin
        if (wr_msb) marr[HI:8] <= wr_data[HI-8:0];
        else        marr[7:0]  <= wr_data;
      end
      if (wr_en && wr_reg == REG_VWR) begin
        if (wr_msb) wlatch[15:8] <= wr_data;
        else        wlatch[7:0]  <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_vram_access_unit.sv
// Bench for vram_access_unit: random register/VRR traffic against a shadow
// model of the address registers and VRAM contents, checked by a monitor.
module tb_vram_access_unit;

  localparam logic [4:0] R_MAWR = 5'h00;
  localparam logic [4:0] R_MARR = 5'h01;
  localparam logic [4:0] R_VWR  = 5'h02;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_en, wr_msb, vrr_rd_msb, slot_free;
  logic [4:0]  wr_reg;
  logic [7:0]  wr_data;
  logic [1:0]  incr_sel;
  logic [15:0] vram_addr, vram_wdata, vram_rdata, vrr_data;
  logic        vram_we, vram_re, busy, dropped;

  vram_access_unit dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_msb(wr_msb),
    .wr_reg(wr_reg), .wr_data(wr_data), .vrr_rd_msb(vrr_rd_msb),
    .incr_sel(incr_sel), .slot_free(slot_free), .vram_addr(vram_addr),
    .vram_we(vram_we), .vram_re(vram_re), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata), .vrr_data(vrr_data), .busy(busy), .dropped(dropped)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int exp_drops = 0;
  int act_drops = 0;

  // expected accesses: {is_write, addr, wdata}; expected prefetch results
  logic [32:0] exp_q[$];
  logic [15:0] vrr_q[$];

  // reference model state
  logic [15:0] m_mawr, m_marr, m_wl;
  logic [15:0] ref_mem [0:65535];
  logic [15:0] vmem    [0:65535];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return (a == 16'h0100) ? 16'h5A5A : (p ^ 16'hC3A5);
  endfunction

  function automatic logic [15:0] inc_of(input logic [1:0] s);
    case (s)
      2'd0:    return 16'd1;
      2'd1:    return 16'd32;
      2'd2:    return 16'd64;
      default: return 16'd128;
    endcase
  endfunction

  // VRAM responder: data appears the cycle after the read strobe, garbage otherwise
  initial begin
    logic [15:0] rd_hold;
    for (int i = 0; i < 65536; i++) vmem[i] = pat(16'(i));
    vram_rdata = 16'h0;
    forever begin
      @(negedge clock);
      if (vram_we) vmem[vram_addr] = vram_wdata;
      rd_hold = vram_re ? vmem[vram_addr] : 16'($urandom);
      @(posedge clock);
      vram_rdata <= rd_hold;
    end
  end

  // monitor: compares every strobe and every prefetch result
  initial begin
    int rd_cnt;
    logic [32:0] e;
    rd_cnt = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        rd_cnt = 0;
      end else begin
        if (dropped) act_drops++;
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            if (vrr_q.size() == 0) check("vrr_unexpected", 33'(vrr_data), 33'h1_0000_0000);
            else check("vrr_data", 33'(vrr_data), 33'(vrr_q.pop_front()));
          end
        end
        if (vram_we && vram_re) check("we_re_both", 33'd1, 33'd0);
        if (vram_we || vram_re) begin
          if (exp_q.size() == 0) begin
            check("access_unexpected", {vram_we, vram_addr, vram_wdata}, 33'h0);
          end else begin
            e = exp_q.pop_front();
            check(vram_we ? "write_access" : "read_access",
                  {vram_we, vram_addr, vram_we ? vram_wdata : 16'h0}, e);
          end
          if (vram_re) rd_cnt = 2;
        end
        if (!busy) check("idle_addr", 33'(vram_addr), 33'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    wr_en = 1'b0; wr_msb = 1'b0; wr_reg = 5'h0; wr_data = 8'h0; vrr_rd_msb = 1'b0;
  endtask

  task automatic model_byte(input logic [4:0] r, input logic msb, input logic [7:0] d);
    if (r == R_MAWR) begin if (msb) m_mawr[15:8] = d; else m_mawr[7:0] = d; end
    if (r == R_MARR) begin if (msb) m_marr[15:8] = d; else m_marr[7:0] = d; end
    if (r == R_VWR)  begin if (msb) m_wl[15:8]   = d; else m_wl[7:0]   = d; end
  endtask

  // idle-time byte write; slot_free is random since nothing may use it
  task automatic byte_wr(input logic [4:0] r, input logic msb, input logic [7:0] d);
    wr_en = 1'b1; wr_reg = r; wr_msb = msb; wr_data = d;
    slot_free = 1'($urandom);
    model_byte(r, msb, d);
    tick();
    drive_idle();
  endtask

  // one busy cycle with no slot; inj: 0 none, 1 VWR MSB, 2 MARR MSB,
  // 3 vrr_rd_msb, 4 MAWR LSB, 5 random pick
  task automatic stall_cycle(input int inj);
    int k;
    logic trig;
    logic [7:0] d;
    k = (inj == 5) ? $urandom_range(0, 4) : inj;
    d = 8'($urandom);
    trig = 1'b0;
    slot_free = 1'b0;
    case (k)
      1: begin wr_en = 1; wr_reg = R_VWR;  wr_msb = 1; wr_data = d; model_byte(R_VWR, 1, d);  trig = 1; end
      2: begin wr_en = 1; wr_reg = R_MARR; wr_msb = 1; wr_data = d; model_byte(R_MARR, 1, d); trig = 1; end
      3: begin vrr_rd_msb = 1; m_marr = m_marr + inc_of(incr_sel); trig = 1; end
      4: begin wr_en = 1; wr_reg = R_MAWR; wr_msb = 0; wr_data = d; model_byte(R_MAWR, 0, d); end
      default: ;
    endcase
    tick();
    drive_idle();
    if (trig) exp_drops++;
    check("stall_dropped", 33'(dropped), 33'(trig));
    check("stall_busy", 33'(busy), 33'd1);
  endtask

  task automatic write_trig(input logic [7:0] hi, input logic with_vrr);
    wr_en = 1'b1; wr_reg = R_VWR; wr_msb = 1'b1; wr_data = hi;
    vrr_rd_msb = with_vrr;
    slot_free = 1'($urandom);
    model_byte(R_VWR, 1, hi);
    if (with_vrr) begin
      m_marr = m_marr + inc_of(incr_sel);
      exp_drops++;
    end
    tick();
    drive_idle();
    check("wtrig_busy", 33'(busy), 33'd1);
    check("wtrig_dropped", 33'(dropped), 33'(with_vrr));
  endtask

  task automatic write_finish(input int stall, input int inj);
    for (int i = 0; i < stall; i++) stall_cycle(i == 0 || inj == 5 ? inj : 0);
    slot_free = 1'b1;
    exp_q.push_back({1'b1, m_mawr, m_wl});
    ref_mem[m_mawr] = m_wl;
    m_mawr = m_mawr + inc_of(incr_sel);
    tick();
    slot_free = 1'b0;
    check("wdone_busy", 33'(busy), 33'd0);
  endtask

  task automatic write_op(input logic [7:0] lo, input logic [7:0] hi, input int stall,
                          input int inj, input logic with_vrr);
    byte_wr(R_VWR, 1'b0, lo);
    write_trig(hi, with_vrr);
    write_finish(stall, inj);
  endtask

  task automatic read_op(input logic via_vrr, input logic [7:0] lo, input logic [7:0] hi,
                         input int stall, input int inj);
    if (via_vrr) begin
      vrr_rd_msb = 1'b1;
      slot_free = 1'($urandom);
      m_marr = m_marr + inc_of(incr_sel);
      tick();
      drive_idle();
    end else begin
      byte_wr(R_MARR, 1'b0, lo);
      byte_wr(R_MARR, 1'b1, hi);
    end
    check("rtrig_busy", 33'(busy), 33'd1);
    check("rtrig_dropped", 33'(dropped), 33'd0);
    for (int i = 0; i < stall; i++) stall_cycle(i == 0 || inj == 5 ? inj : 0);
    slot_free = 1'b1;
    exp_q.push_back({1'b0, m_marr, 16'h0});
    vrr_q.push_back(ref_mem[m_marr]);
    tick();
    slot_free = 1'($urandom);
    check("rwait_busy", 33'(busy), 33'd1);
    tick();
    slot_free = 1'b0;
    check("rdone_busy", 33'(busy), 33'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(16'(i));
    m_mawr = 16'h0; m_marr = 16'h0; m_wl = 16'h0;
    drive_idle();
    slot_free = 1'b0;
    incr_sel = 2'b00;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_busy", 33'(busy), 33'd0);
    check("rst_dropped", 33'(dropped), 33'd0);
    check("rst_vrr_data", 33'(vrr_data), 33'd0);
    check("rst_addr", 33'(vram_addr), 33'd0);

    // simple write, then consecutive address
    byte_wr(R_MAWR, 1'b0, 8'h34);
    byte_wr(R_MAWR, 1'b1, 8'h12);
    write_op(8'hCD, 8'hAB, 0, 0, 1'b0);
    write_op(8'h11, 8'h22, 0, 0, 1'b0);

    // prefetch from 0x0100, then VRR MSB read stepping by 32
    read_op(1'b0, 8'h00, 8'h01, 0, 0);
    incr_sel = 2'b01;
    read_op(1'b1, 8'h00, 8'h00, 0, 0);

    // five-cycle slot stall
    incr_sel = 2'b00;
    write_op(8'h5E, 8'hA1, 5, 0, 1'b0);

    // wrap with +128
    incr_sel = 2'b11;
    byte_wr(R_MAWR, 1'b0, 8'hC0);
    byte_wr(R_MAWR, 1'b1, 8'hFF);
    write_op(8'h01, 8'h02, 0, 0, 1'b0);
    write_op(8'h03, 8'h04, 0, 0, 1'b0);

    // collisions: VWR MSB while read pending; WT with VRR read in idle
    incr_sel = 2'b00;
    read_op(1'b0, 8'h40, 8'h02, 2, 1);
    write_op(8'h66, 8'h77, 0, 0, 1'b1);
    read_op(1'b1, 8'h00, 8'h00, 0, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      incr_sel = 2'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          byte_wr(R_MAWR, 1'b0, 8'($urandom));
          byte_wr(R_MAWR, 1'b1, 8'($urandom));
        end
        write_op(8'($urandom), 8'($urandom), $urandom_range(0, 4),
                 $urandom_range(0, 1) * 5, $urandom_range(0, 5) == 0);
      end else begin
        read_op(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 4),
                $urandom_range(0, 1) * 5);
      end
      repeat ($urandom_range(0, 2)) byte_wr(5'h1F, 1'b0, 8'h00);
    end

    // reset during a granted write
    incr_sel = 2'b00;
    byte_wr(R_MAWR, 1'b0, 8'h99);
    write_trig(8'h77, 1'b0);
    stall_cycle(0);
    slot_free = 1'b1;
    #1;
    check("pre_rst_we", 33'(vram_we), 33'd1);
    reset_n = 1'b0;
    #1;
    check("rst_we_drop", 33'(vram_we), 33'd0);
    check("rst_busy_drop", 33'(busy), 33'd0);
    @(negedge clock);
    #2;
    slot_free = 1'b0;
    reset_n = 1'b1;
    m_mawr = 16'h0; m_marr = 16'h0; m_wl = 16'h0;
    tick();
    check("rst2_vrr_data", 33'(vrr_data), 33'd0);
    check("rst2_busy", 33'(busy), 33'd0);
    // cleared registers show up in the next accesses
    write_trig(8'h3C, 1'b0);
    write_finish(0, 0);
    byte_wr(R_MARR, 1'b1, 8'h00);
    check("rst2_rtrig_busy", 33'(busy), 33'd1);
    slot_free = 1'b1;
    exp_q.push_back({1'b0, m_marr, 16'h0});
    vrr_q.push_back(ref_mem[m_marr]);
    tick();
    slot_free = 1'b0;
    repeat (3) tick();

    check("drop_count", 33'(act_drops), 33'(exp_drops));
    check("exp_q_drained", 33'(exp_q.size()), 33'd0);
    check("vrr_q_drained", 33'(vrr_q.size()), 33'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
